// File: rtl/proxy_pool_arbiter_pkg.sv
// proxy_pool_arbiter_pkg: slot state encodings and settings constants shared with the column controller
package proxy_pool_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD1   = 2'd1,
        S_LOAD2   = 2'd2,
        S_COMPUTE = 2'd3
    } slot_state_e;

    localparam logic [2:0] SET_IDLE    = 3'b000;
    localparam logic [2:0] SET_LOAD    = 3'b001;
    localparam logic [2:0] SET_COMPUTE = 3'b110;

    function automatic logic [2:0] settings_of(slot_state_e st);
        return st == S_COMPUTE ? SET_COMPUTE :
               (st == S_LOAD1 || st == S_LOAD2) ? SET_LOAD : SET_IDLE;
    endfunction

endpackage

// File: rtl/proxy_pool_arbiter_rr_arbiter.sv
// proxy_pool_arbiter_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module proxy_pool_arbiter_rr_arbiter #(
    parameter int COLS = 4,
    localparam int COL_W = $clog2(COLS)
) (
    input  logic [COLS-1:0]  req,
    input  logic [COL_W-1:0] ptr,
    output logic [COLS-1:0]  gnt,
    output logic [COL_W-1:0] idx
);

    logic [COL_W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        j   = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            j = COL_W'((int'(ptr) + i) % COLS);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/proxy_pool_arbiter.sv
// proxy_pool_arbiter: round-robin allocation of shared proxy PE slots to faulting columns
module proxy_pool_arbiter
    import proxy_pool_arbiter_pkg::*;
#(
    parameter int COLS = 4,
    parameter int NUM_PROXY = 2,
    localparam int COL_W = $clog2(COLS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COLS-1:0]            fault_req,
    input  logic [COLS-1:0]            col_release,
    input  logic                       weights_reload,
    output logic [COLS-1:0]            col_grant,
    output logic [NUM_PROXY-1:0]       slot_busy,
    output logic [NUM_PROXY*COL_W-1:0] slot_col,
    output logic [NUM_PROXY-1:0]       load_proxy,
    output logic [NUM_PROXY-1:0]       proxy_matmul,
    output logic [NUM_PROXY*3-1:0]     proxy_settings,
    output logic                       pool_exhausted
);

    logic [COLS-1:0]      col_grant_q, col_grant_d, eligible, win_oh;
    logic [COL_W-1:0]     rr_ptr_q, rr_ptr_d, win_idx;
    logic [NUM_PROXY-1:0] idle, free_oh;
    logic                 alloc;

    assign eligible       = fault_req & ~col_grant_q;
    assign free_oh        = idle & (~idle + 1'b1);
    assign alloc          = |eligible && |idle && !weights_reload;
    assign pool_exhausted = |eligible && !(|idle);
    assign col_grant      = col_grant_q;
    assign slot_busy      = ~idle;

    proxy_pool_arbiter_rr_arbiter #(.COLS(COLS)) u_rr (
        .req(eligible),
        .ptr(rr_ptr_q),
        .gnt(win_oh),
        .idx(win_idx)
    );

    always_comb begin
        col_grant_d = weights_reload ? '0 : (col_grant_q & ~col_release) | (alloc ? win_oh : '0);
        rr_ptr_d    = !alloc ? rr_ptr_q : win_idx == COL_W'(COLS - 1) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_grant_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            col_grant_q <= col_grant_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    for (genvar s = 0; s < NUM_PROXY; s++) begin : g_slot
        slot_state_e      state_q, state_d;
        logic [COL_W-1:0] col_q, col_d;
        always_comb begin
            col_d   = col_q;
            state_d = state_q == S_LOAD1 ? S_LOAD2 : state_q == S_LOAD2 ? S_COMPUTE : state_q;
            if (state_q != S_IDLE && col_release[col_q] && col_grant_q[col_q])
                state_d = S_IDLE;
            if (alloc && free_oh[s]) begin
                state_d = S_LOAD1;
                col_d   = win_idx;
            end
            if (weights_reload)
                state_d = S_IDLE;
        end
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= S_IDLE;
                col_q   <= '0;
            end else begin
                state_q <= state_d;
                col_q   <= col_d;
            end
        end
        assign idle[s]                    = state_q == S_IDLE;
        assign load_proxy[s]              = state_q == S_LOAD1 || state_q == S_LOAD2;
        assign proxy_matmul[s]            = state_q == S_COMPUTE;
        assign proxy_settings[s*3 +: 3]   = settings_of(state_q);
        assign slot_col[s*COL_W +: COL_W] = col_q;
    end

endmodule

// File: tb/tb_proxy_pool_arbiter.sv
// tb_proxy_pool_arbiter: directed and random checks against an owner/age reference model
module tb_proxy_pool_arbiter;

    localparam int NC = 4;
    localparam int NP = 2;

    logic          clk, rst, weights_reload;
    logic [NC-1:0] fault_req, col_release, col_grant;
    logic [NP-1:0] slot_busy, load_proxy, proxy_matmul;
    logic [NP*2-1:0] slot_col;
    logic [NP*3-1:0] proxy_settings;
    logic          pool_exhausted;

    int passed = 0;
    int total  = 0;
    int owner [NP];
    int age   [NP];
    int rr;

    proxy_pool_arbiter dut (
        .clk(clk), .rst(rst), .fault_req(fault_req), .col_release(col_release),
        .weights_reload(weights_reload), .col_grant(col_grant), .slot_busy(slot_busy),
        .slot_col(slot_col), .load_proxy(load_proxy), .proxy_matmul(proxy_matmul),
        .proxy_settings(proxy_settings), .pool_exhausted(pool_exhausted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit is_granted(int c);
        for (int s = 0; s < NP; s++) if (owner[s] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic r, input logic [NC-1:0] req, input logic [NC-1:0] rel, input logic wr);
        logic [NC-1:0] e_grant;
        logic [NP-1:0] e_busy, e_load, e_mm;
        logic [NP*2-1:0] e_col, m_col;
        logic [NP*3-1:0] e_set;
        bit any_elig, all_busy;
        int win, fs;
        @(negedge clk);
        rst = r; fault_req = req; col_release = rel; weights_reload = wr;
        #1;
        any_elig = 1'b0;
        all_busy = 1'b1;
        for (int c = 0; c < NC; c++) if (req[c] && !is_granted(c)) any_elig = 1'b1;
        for (int s = 0; s < NP; s++) if (owner[s] < 0) all_busy = 1'b0;
        chk("pool_exhausted", 32'(pool_exhausted), 32'(any_elig && all_busy));
        @(posedge clk);
        if (!r) begin
            for (int s = 0; s < NP; s++) begin owner[s] = -1; age[s] = 0; end
            rr = 0;
        end else if (wr) begin
            for (int s = 0; s < NP; s++) owner[s] = -1;
        end else begin
            win = -1;
            fs  = -1;
            for (int k = 0; k < NC; k++)
                if (win < 0 && req[(rr + k) % NC] && !is_granted((rr + k) % NC)) win = (rr + k) % NC;
            for (int s = NP - 1; s >= 0; s--) if (owner[s] < 0) fs = s;
            for (int s = 0; s < NP; s++)
                if (owner[s] >= 0 && rel[owner[s]]) owner[s] = -1;
                else if (owner[s] >= 0 && age[s] < 2) age[s]++;
            if (win >= 0 && fs >= 0) begin
                owner[fs] = win;
                age[fs]   = 0;
                rr        = (win + 1) % NC;
            end
        end
        #1;
        e_grant = '0; e_busy = '0; e_load = '0; e_mm = '0; e_col = '0; m_col = '0; e_set = '0;
        for (int s = 0; s < NP; s++) if (owner[s] >= 0) begin
            e_grant[owner[s]] = 1'b1;
            e_busy[s]         = 1'b1;
            e_col[s*2 +: 2]   = 2'(owner[s]);
            m_col[s*2 +: 2]   = 2'b11;
            e_load[s]         = age[s] < 2;
            e_mm[s]           = age[s] >= 2;
            e_set[s*3 +: 3]   = age[s] >= 2 ? 3'b110 : 3'b001;
        end
        chk("col_grant", 32'(col_grant), 32'(e_grant));
        chk("slot_busy", 32'(slot_busy), 32'(e_busy));
        chk("slot_col", 32'(slot_col & m_col), 32'(e_col));
        chk("load_proxy", 32'(load_proxy), 32'(e_load));
        chk("proxy_matmul", 32'(proxy_matmul), 32'(e_mm));
        chk("proxy_settings", 32'(proxy_settings), 32'(e_set));
    endtask

    initial begin
        rst = 1'b0; fault_req = '0; col_release = '0; weights_reload = 1'b0;
        for (int s = 0; s < NP; s++) begin owner[s] = -1; age[s] = 0; end
        rr = 0;
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("reset_slot_col", 32'(slot_col), 32'h0);
        chk("reset_settings", 32'(proxy_settings), 32'h0);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        chk("first_grant", 32'(col_grant), 32'b0100);
        chk("first_slot_col", 32'(slot_col[1:0]), 32'd2);
        chk("first_load1", 32'(proxy_settings[2:0]), 32'b001);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        chk("first_load2", 32'(proxy_settings[2:0]), 32'b001);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        chk("first_compute", 32'(proxy_settings[2:0]), 32'b110);
        step(1'b1, 4'b1001, 4'b0000, 1'b0);
        chk("rr_col3_wins", 32'(col_grant), 32'b1100);
        chk("rr_slot1_col", 32'(slot_col[3:2]), 32'd3);
        step(1'b1, 4'b1001, 4'b0100, 1'b0);
        chk("release_no_same_cycle", 32'(col_grant), 32'b1000);
        step(1'b1, 4'b1001, 4'b0000, 1'b0);
        chk("rr_wrapped_col0", 32'(col_grant), 32'b1001);
        step(1'b1, 4'b0110, 4'b0000, 1'b1);
        chk("reload_clears", 32'(col_grant), 32'b0000);
        step(1'b1, 4'b0110, 4'b0000, 1'b0);
        chk("after_reload_grant", 32'(col_grant), 32'b0010);
        step(1'b1, 4'b0110, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        chk("midreset_busy", 32'(slot_busy), 32'b00);
        step(1'b1, 4'b1111, 4'b0000, 1'b0);
        chk("regrant_col0", 32'(col_grant), 32'b0001);
        step(1'b1, 4'b1111, 4'b0000, 1'b0);
        chk("regrant_col1", 32'(col_grant), 32'b0011);
        step(1'b1, 4'b1111, 4'b0000, 1'b0);
        chk("exhausted", 32'(pool_exhausted), 32'd1);
        step(1'b1, 4'b1111, 4'b0001, 1'b0);
        chk("slot0_freed", 32'(slot_busy), 32'b10);
        step(1'b1, 4'b1111, 4'b0000, 1'b0);
        chk("col2_into_slot0", 32'(slot_col[1:0]), 32'd2);
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 63) != 0, 4'($urandom), 4'($urandom & $urandom), $urandom_range(0, 31) == 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
